// File: rtl/jtag_pkg.sv
// TAP state encoding, next-state function and fixed instruction codes.
// Pure declarations: no latency or backpressure of its own.
package jtag_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_IDLE         = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_t;

  localparam int IR_IDCODE    = 1;
  localparam int IR_USER_BASE = 2;

  function automatic int unsigned ir_bypass(input int ir_len);
    return (32'd1 << ir_len) - 32'd1;
  endfunction

  function automatic tap_state_t next_tap_state(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = TEST_LOGIC_RESET;
    case (s)
      TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_IDLE;
      RUN_IDLE:         n = tms ? SELECT_DR : RUN_IDLE;
      SELECT_DR:        n = tms ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR:       n = tms ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:         n = tms ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:         n = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:         n = tms ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:         n = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:        n = tms ? SELECT_DR : RUN_IDLE;
      SELECT_IR:        n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       n = tms ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:         n = tms ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:         n = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:         n = tms ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:         n = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:        n = tms ? SELECT_DR : RUN_IDLE;
      default:          n = TEST_LOGIC_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller with registered per-state action flags.
// Flags are valid in the same cycle as the state they decode; no backpressure.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_t state,
  output logic       cap_ir,
  output logic       sh_ir,
  output logic       upd_ir,
  output logic       cap_dr,
  output logic       sh_dr,
  output logic       upd_dr
);

  tap_state_t nxt;
  assign nxt = next_tap_state(state, tms);

  // Flags are decoded from the next state so they line up with the registered state.
  always_ff @(posedge tck) begin
    if (!trst) begin
      state  <= TEST_LOGIC_RESET;
      cap_ir <= 1'b0;
      sh_ir  <= 1'b0;
      upd_ir <= 1'b0;
      cap_dr <= 1'b0;
      sh_dr  <= 1'b0;
      upd_dr <= 1'b0;
    end else begin
      state  <= nxt;
      cap_ir <= (nxt == CAPTURE_IR);
      sh_ir  <= (nxt == SHIFT_IR);
      upd_ir <= (nxt == UPDATE_IR);
      cap_dr <= (nxt == CAPTURE_DR);
      sh_dr  <= (nxt == SHIFT_DR);
      upd_dr <= (nxt == UPDATE_DR);
    end
  end

endmodule

// File: rtl/jtag_user_tap.sv
// TAP with IDCODE, BYPASS and NUM_USER user data registers, each with its own USERk instruction.
// Strobes fire one tck after Capture-DR / Update-DR; the host cannot stall, there is no backpressure.
module jtag_user_tap
  import jtag_pkg::*;
#(
  parameter int                          IR_LEN     = 4,
  parameter logic [3:0]                  ID_PARTVER = 4'h5,
  parameter logic [15:0]                 ID_PARTNUM = 16'h3817,
  parameter logic [10:0]                 ID_MANF    = 11'h482,
  parameter int                          NUM_USER   = 3,
  parameter int                          DATA_W     = 32,
  parameter logic [NUM_USER*DATA_W-1:0]  DATA_RST   = '0
) (
  input  logic                          tck,
  input  logic                          trst,
  input  logic                          tms,
  input  logic                          tdi,
  output logic                          tdo,
  input  logic [NUM_USER*DATA_W-1:0]    user_rd_data,
  output logic [NUM_USER*DATA_W-1:0]    user_wr_data,
  output logic [NUM_USER-1:0]           user_wr_valid,
  output logic [NUM_USER-1:0]           user_rd_strobe
);

  localparam logic [IR_LEN-1:0] IR_ID     = IR_LEN'(IR_IDCODE);
  localparam logic [IR_LEN-1:0] IR_BYPASS = IR_LEN'(ir_bypass(IR_LEN));
  localparam logic [31:0]       ID_VALUE  = {ID_PARTVER, ID_PARTNUM, ID_MANF, 1'b1};

  tap_state_t state;
  logic cap_ir, sh_ir, upd_ir, cap_dr, sh_dr, upd_dr;

  jtag_tap_fsm u_fsm (
    .tck    (tck),
    .trst   (trst),
    .tms    (tms),
    .state  (state),
    .cap_ir (cap_ir),
    .sh_ir  (sh_ir),
    .upd_ir (upd_ir),
    .cap_dr (cap_dr),
    .sh_dr  (sh_dr),
    .upd_dr (upd_dr)
  );

  logic [IR_LEN-1:0]   ir;
  logic [IR_LEN-1:0]   ir_sr;
  logic [31:0]         id_sr;
  logic                byp_sr;
  logic [DATA_W-1:0]   user_sr;
  logic                shifted;

  logic                sel_id;
  logic [NUM_USER-1:0] user_sel;
  logic                sel_user;
  logic [DATA_W-1:0]   rd_slice;

  // Any code that is neither IDCODE nor a valid USERk falls through to BYPASS.
  always_comb begin
    sel_id   = (ir == IR_ID);
    user_sel = '0;
    rd_slice = '0;
    for (int k = 0; k < NUM_USER; k++) begin
      user_sel[k] = (ir != IR_BYPASS) && (ir == IR_LEN'(IR_USER_BASE + k));
      if (user_sel[k]) rd_slice = user_rd_data[k*DATA_W +: DATA_W];
    end
    sel_user = |user_sel;
  end

  always_comb begin
    tdo = 1'b0;
    if (sh_ir)        tdo = ir_sr[0];
    else if (sh_dr) begin
      if (sel_id)        tdo = id_sr[0];
      else if (sel_user) tdo = user_sr[0];
      else               tdo = byp_sr;
    end
  end

  always_ff @(posedge tck) begin
    if (!trst) begin
      ir             <= IR_ID;
      ir_sr          <= '0;
      id_sr          <= '0;
      byp_sr         <= 1'b0;
      user_sr        <= '0;
      shifted        <= 1'b0;
      user_wr_data   <= DATA_RST;
      user_wr_valid  <= '0;
      user_rd_strobe <= '0;
    end else begin
      user_wr_valid  <= '0;
      user_rd_strobe <= '0;

      if (state == TEST_LOGIC_RESET) ir <= IR_ID;

      if (cap_ir)     ir_sr <= IR_LEN'(1);
      else if (sh_ir) ir_sr <= {tdi, ir_sr[IR_LEN-1:1]};
      if (upd_ir)     ir    <= ir_sr;

      if (cap_dr) begin
        shifted        <= 1'b0;
        id_sr          <= ID_VALUE;
        byp_sr         <= 1'b0;
        user_sr        <= rd_slice;
        user_rd_strobe <= user_sel;
      end else if (sh_dr) begin
        shifted <= 1'b1;
        if (sel_id)        id_sr   <= {tdi, id_sr[31:1]};
        else if (sel_user) user_sr <= {tdi, user_sr[DATA_W-1:1]};
        else               byp_sr  <= tdi;
      end

      // A capture-only pass through Update-DR must not clobber the user register.
      if (upd_dr && shifted) begin
        for (int k = 0; k < NUM_USER; k++) begin
          if (user_sel[k]) begin
            user_wr_data[k*DATA_W +: DATA_W] <= user_sr;
            user_wr_valid[k]                 <= 1'b1;
          end
        end
      end
    end
  end

endmodule
